// File: rtl/pathfinding_pkg.sv
// Shared types for the pathfinding front end.
//   wrState_t : state encoding of the coordinate store writer
//   coord_t   : packed (x,y) pair at the default coordinate width
//   DEF_COORD_W : default width of one coordinate component
package pathfinding_pkg;

  localparam int DEF_COORD_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    WRITE  = 2'd2,
    SEALED = 2'd3
  } wrState_t;

  typedef struct packed {
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
  } coord_t;

endpackage

// File: rtl/coord_regfile.sv
// Register file holding the unique node coordinates.
//   clk, reset        : clock; reset clears only the registered read data
//   wr_en/wr_addr     : single write port, stores {wr_x, wr_y}
//   scan_idx          : combinational compare-read port -> scan_x/scan_y
//   rd_load/rd_clear  : registered read port control; load captures
//                       mem[rd_addr], clear forces the read data to zero,
//                       neither holds the previous read data
//   rd_x/rd_y         : registered read data
// The array itself is never reset; the writer's count says which entries
// hold meaningful data.
module coord_regfile
  import pathfinding_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [ADDR_W-1:0]  scan_idx,
  output logic [COORD_W-1:0] scan_x,
  output logic [COORD_W-1:0] scan_y,
  input  logic               rd_load,
  input  logic               rd_clear,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y
);

  logic [2*COORD_W-1:0] mem [DEPTH];
  logic [2*COORD_W-1:0] rd_q_p1;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {wr_x, wr_y};
    end
  end

  assign scan_x = mem[scan_idx][2*COORD_W-1:COORD_W];
  assign scan_y = mem[scan_idx][COORD_W-1:0];

  // read stage boundary: one cycle from rd_addr to rd_x/rd_y
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q_p1 <= '0;
    end else if (rd_load) begin
      rd_q_p1 <= mem[rd_addr];
    end else if (rd_clear) begin
      rd_q_p1 <= '0;
    end
  end

  assign rd_x = rd_q_p1[2*COORD_W-1:COORD_W];
  assign rd_y = rd_q_p1[COORD_W-1:0];

endmodule

// File: rtl/coord_mem_writer.sv
// Coordinate store writer, downstream of the coordinate-entry FSM.
// Accepts one (x,y) per valid/ready handshake, scans the stored entries
// one per cycle to drop duplicates, appends unique pairs, and once
// finish_init is seen in IDLE seals the store and serves reads.
//   clk, reset              : clock, synchronous active-high reset
//   coord_valid/x/y, ready  : input handshake for one coordinate pair
//   finish_init             : level request to seal the store
//   rd_en, rd_addr          : read request, honoured only when sealed
//   rd_x, rd_y, rd_valid    : registered read response (1-cycle latency)
//   count, full             : stored entries, count == DEPTH
//   dup_drop                : one-cycle pulse on duplicate rejection
//   err_overflow            : sticky, coord_valid while full and unsealed
//   done                    : store sealed
module coord_mem_writer
  import pathfinding_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               coord_valid,
  input  logic [COORD_W-1:0] coord_x,
  input  logic [COORD_W-1:0] coord_y,
  output logic               coord_ready,
  input  logic               finish_init,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic               rd_valid,
  output logic [ADDR_W:0]    count,
  output logic               full,
  output logic               dup_drop,
  output logic               err_overflow,
  output logic               done
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

  wrState_t           state;
  logic [ADDR_W-1:0]  scan_idx;
  logic [COORD_W-1:0] pend_x;
  logic [COORD_W-1:0] pend_y;
  logic [COORD_W-1:0] scan_x;
  logic [COORD_W-1:0] scan_y;
  logic [ADDR_W:0]    count_m1;
  logic               xfer;
  logic               scan_match;
  logic               scan_last;
  logic               wr_en;
  logic               rd_hit;
  logic               rd_clear;

  assign full        = (count == DEPTH_CNT);
  assign coord_ready = (state == IDLE) && !full && !reset;
  assign xfer        = coord_valid && coord_ready;

  assign count_m1   = count - CNT_ONE;
  assign scan_match = (scan_x == pend_x) && (scan_y == pend_y);
  assign scan_last  = ({1'b0, scan_idx} == count_m1);

  // count never exceeds DEPTH, so the guard only matters if the FSM were
  // ever to reach WRITE with a full store.
  assign wr_en = (state == WRITE) && !full;

  assign rd_hit   = rd_en && (state == SEALED) && ({1'b0, rd_addr} < count);
  assign rd_clear = rd_en && !rd_hit;

  // Pending pair is data: captured on transfer, never reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      pend_x <= coord_x;
      pend_y <= coord_y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      scan_idx     <= '0;
      dup_drop     <= 1'b0;
      err_overflow <= 1'b0;
      done         <= 1'b0;
      rd_valid     <= 1'b0;
    end else begin
      dup_drop <= 1'b0;
      rd_valid <= rd_hit;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (count == '0) begin
              state <= WRITE;
            end else begin
              scan_idx <= '0;
              state    <= SCAN;
            end
          end else begin
            if (coord_valid && full) begin
              err_overflow <= 1'b1;
            end
            // A transfer wins over finish_init; sealing waits for the
            // next IDLE cycle in which finish_init is still high.
            if (finish_init) begin
              state <= SEALED;
              done  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (scan_match) begin
            dup_drop <= 1'b1;
            state    <= IDLE;
          end else if (scan_last) begin
            state <= WRITE;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        WRITE: begin
          if (!full) begin
            count <= count + CNT_ONE;
          end
          state <= IDLE;
        end
        SEALED: begin
          done <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  coord_regfile #(
    .COORD_W (COORD_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (count[ADDR_W-1:0]),
    .wr_x     (pend_x),
    .wr_y     (pend_y),
    .scan_idx (scan_idx),
    .scan_x   (scan_x),
    .scan_y   (scan_y),
    .rd_load  (rd_hit),
    .rd_clear (rd_clear),
    .rd_addr  (rd_addr),
    .rd_x     (rd_x),
    .rd_y     (rd_y)
  );

endmodule

// File: tb/tb_coord_mem_writer.sv
module tb_coord_mem_writer;

  localparam int COORD_W = 8;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               coord_valid;
  logic [COORD_W-1:0] coord_x;
  logic [COORD_W-1:0] coord_y;
  logic               coord_ready;
  logic               finish_init;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic               rd_valid;
  logic [ADDR_W:0]    count;
  logic               full;
  logic               dup_drop;
  logic               err_overflow;
  logic               done;

  int n_tests = 0;
  int n_fail  = 0;

  coord_mem_writer #(
    .COORD_W (COORD_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .coord_valid  (coord_valid),
    .coord_x      (coord_x),
    .coord_y      (coord_y),
    .coord_ready  (coord_ready),
    .finish_init  (finish_init),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .dup_drop     (dup_drop),
    .err_overflow (err_overflow),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    coord_valid = 1'b0;
    coord_x     = '0;
    coord_y     = '0;
    finish_init = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    reset       = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Presents one pair, waits (bounded) for the transfer, then watches
  // 8 cycles: lat = cycles until coord_ready is high again, dups = number
  // of dup_drop pulses, dup_at = cycle of the last pulse.
  task automatic send(input logic [7:0] x, input logic [7:0] y,
                      output int lat, output int dups, output int dup_at);
    int w;
    lat = 0; dups = 0; dup_at = 0; w = 0;
    coord_x = x;
    coord_y = y;
    coord_valid = 1'b1;
    while (!coord_ready && w < 20) begin
      tick();
      w++;
    end
    if (!coord_ready) begin
      chk("ready_wait", 32'(coord_ready), 32'd1);
      coord_valid = 1'b0;
      return;
    end
    tick();
    coord_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (dup_drop) begin
        dups++;
        dup_at = i;
      end
      if (lat == 0 && coord_ready) lat = i;
      if (i < 8) tick();
    end
  endtask

  initial begin
    int lat, dups, dup_at, tot_dups;

    // Reset state
    coord_valid = 1'b0; coord_x = '0; coord_y = '0;
    finish_init = 1'b0; rd_en = 1'b0; rd_addr = '0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(coord_ready), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_x", 32'(rd_x), 32'd0);
    chk("rst_rd_y", 32'(rd_y), 32'd0);
    chk("rst_dup", 32'(dup_drop), 32'd0);
    chk("rst_err", 32'(err_overflow), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(coord_ready), 32'd1);

    // Three unique pairs: latencies count+2
    tot_dups = 0;
    send(8'd3, 8'd5, lat, dups, dup_at);
    chk("lat_first", 32'(lat), 32'd2);
    tot_dups += dups;
    send(8'd7, 8'd2, lat, dups, dup_at);
    chk("lat_second", 32'(lat), 32'd3);
    tot_dups += dups;
    send(8'd9, 8'd9, lat, dups, dup_at);
    chk("lat_third", 32'(lat), 32'd4);
    tot_dups += dups;
    chk("uniq_count", 32'(count), 32'd3);
    chk("uniq_no_dup", 32'(tot_dups), 32'd0);

    // Duplicate at index 1
    do_reset();
    send(8'd3, 8'd5, lat, dups, dup_at);
    send(8'd7, 8'd2, lat, dups, dup_at);
    send(8'd7, 8'd2, lat, dups, dup_at);
    chk("dup_pulses", 32'(dups), 32'd1);
    chk("dup_at", 32'(dup_at), 32'd3);
    chk("dup_lat", 32'(lat), 32'd3);
    chk("dup_count", 32'(count), 32'd2);
    // Same x, different y is not a duplicate
    send(8'd7, 8'd3, lat, dups, dup_at);
    chk("partial_match_dups", 32'(dups), 32'd0);
    chk("partial_match_count", 32'(count), 32'd3);

    // Fill to DEPTH and overflow
    do_reset();
    send(8'd1, 8'd2, lat, dups, dup_at);
    send(8'd3, 8'd4, lat, dups, dup_at);
    send(8'd5, 8'd6, lat, dups, dup_at);
    send(8'd7, 8'd8, lat, dups, dup_at);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(coord_ready), 32'd0);
    chk("fill_err_before", 32'(err_overflow), 32'd0);
    coord_x = 8'd11; coord_y = 8'd12; coord_valid = 1'b1;
    tick();
    coord_valid = 1'b0;
    chk("ovf_err", 32'(err_overflow), 32'd1);
    tick();
    tick();
    chk("ovf_err_sticky", 32'(err_overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);

    // Transfer and finish_init together
    do_reset();
    coord_x = 8'd1; coord_y = 8'd1; coord_valid = 1'b1; finish_init = 1'b1;
    tick();
    coord_valid = 1'b0;
    chk("fi_write_done", 32'(done), 32'd0);
    tick();
    chk("fi_idle_count", 32'(count), 32'd1);
    chk("fi_idle_done", 32'(done), 32'd0);
    tick();
    chk("fi_sealed_done", 32'(done), 32'd1);
    chk("fi_sealed_ready", 32'(coord_ready), 32'd0);
    rd_en = 1'b1; rd_addr = 2'd0;
    tick();
    rd_en = 1'b0;
    chk("fi_rd_valid", 32'(rd_valid), 32'd1);
    chk("fi_rd_x", 32'(rd_x), 32'd1);
    chk("fi_rd_y", 32'(rd_y), 32'd1);
    finish_init = 1'b0;

    // Sealed with count=2: reads in and out of range, ignored input
    do_reset();
    send(8'd4, 8'd4, lat, dups, dup_at);
    send(8'd6, 8'd7, lat, dups, dup_at);
    finish_init = 1'b1;
    tick();
    chk("s2_done", 32'(done), 32'd1);
    rd_en = 1'b1; rd_addr = 2'd1;
    tick();
    chk("s2_rd1_valid", 32'(rd_valid), 32'd1);
    chk("s2_rd1_x", 32'(rd_x), 32'd6);
    chk("s2_rd1_y", 32'(rd_y), 32'd7);
    rd_en = 1'b0;
    tick();
    chk("s2_hold_valid", 32'(rd_valid), 32'd0);
    chk("s2_hold_x", 32'(rd_x), 32'd6);
    chk("s2_hold_y", 32'(rd_y), 32'd7);
    rd_en = 1'b1; rd_addr = 2'd3;
    tick();
    rd_en = 1'b0;
    chk("s2_oob_valid", 32'(rd_valid), 32'd0);
    chk("s2_oob_x", 32'(rd_x), 32'd0);
    chk("s2_oob_y", 32'(rd_y), 32'd0);
    coord_x = 8'd8; coord_y = 8'd8; coord_valid = 1'b1;
    tick();
    tick();
    tick();
    coord_valid = 1'b0;
    chk("s2_ign_count", 32'(count), 32'd2);
    chk("s2_ign_err", 32'(err_overflow), 32'd0);
    chk("s2_ign_ready", 32'(coord_ready), 32'd0);
    finish_init = 1'b0;

    // Read before sealing returns nothing
    do_reset();
    send(8'd2, 8'd2, lat, dups, dup_at);
    rd_en = 1'b1; rd_addr = 2'd0;
    tick();
    rd_en = 1'b0;
    chk("unsealed_rd_valid", 32'(rd_valid), 32'd0);

    // Reset during SCAN with count=3
    do_reset();
    send(8'd1, 8'd1, lat, dups, dup_at);
    send(8'd2, 8'd2, lat, dups, dup_at);
    send(8'd3, 8'd3, lat, dups, dup_at);
    coord_x = 8'd9; coord_y = 8'd9; coord_valid = 1'b1;
    tick();
    coord_valid = 1'b0;
    chk("scan_busy_ready", 32'(coord_ready), 32'd0);
    reset = 1'b1;
    tick();
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ready_in_reset", 32'(coord_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(coord_ready), 32'd1);
    tick();
    chk("mid_rst_count_after", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
